cfg_afu_reset_seq: RTL and testbench

- Sequences OpenCAPI function-1 resets toward the AFU.
- Accepts two reset requests from the config space: a function reset (OFUNC) and an AFU-control reset (OCTRL00).
- For each request it quiesces the AFU, then holds the AFU reset for the advertised reset duration, then releases it and reports completion.
- Sits between cfg_func1 and the AFU. Consumes the read-only reset_duration tie-offs. Drives the in-progress readback bits back to config space.

---
 rtl/cfg_afu_reset_seq.sv | 164 ++++++++++++++++
 tb/tb_cfg_afu_reset_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_afu_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_afu_reset_seq
//  Description : Sequences OpenCAPI function-1 resets toward the AFU. A reset
//                request quiesces the AFU, holds afu_reset for the advertised
//                duration, releases it and reports completion. A function
//                reset arriving during an AFU-control reset escalates it.
//  Revision    : 1.0  initial release
// ============================================================================
module cfg_afu_reset_seq #(
  parameter int UNIT_LOG2       = 4,
  parameter int QUIESCE_TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       func_reset_req,
  input  logic       afu_reset_req,
  input  logic [7:0] ofunc_reset_duration,
  input  logic [7:0] octrl00_reset_duration,
  input  logic       afu_quiesced,
  output logic       afu_reset,
  output logic       func_reset_active,
  output logic       afu_reset_active,
  output logic       reset_done,
  output logic       quiesce_timeout
);

  // Hold counter must cover 255 units of 2^UNIT_LOG2 cycles.
  localparam int HOLD_W = 8 + UNIT_LOG2;
  // Quiesce counter only ever reaches QUIESCE_TIMEOUT-1, so it never wraps.
  localparam int QCNT_W = (QUIESCE_TIMEOUT > 2) ? $clog2(QUIESCE_TIMEOUT) : 1;
  localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(QUIESCE_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [2:0] {
    S_POR     = 3'd0,
    S_IDLE    = 3'd1,
    S_QUIESCE = 3'd2,
    S_ASSERT  = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  typedef enum logic {
    KIND_FUNC = 1'b0,
    KIND_AFU  = 1'b1
  } kind_t;

  state_t            state;
  kind_t             kind;
  logic [HOLD_W-1:0] hold_cnt;
  logic [QCNT_W-1:0] quiesce_cnt;

  // A duration of zero still gives one unit of reset.
  function automatic logic [HOLD_W-1:0] hold_load(input logic [7:0] dur);
    logic [7:0] units;
    units = (dur == 8'd0) ? 8'd1 : dur;
    return HOLD_W'(units) << UNIT_LOG2;
  endfunction

  logic [HOLD_W-1:0] func_hold;
  logic [HOLD_W-1:0] kind_hold;
  logic              escalate;

  // Durations are only consumed at the moment the hold counter is loaded.
  always_comb begin
    func_hold = hold_load(ofunc_reset_duration);
    kind_hold = (kind == KIND_FUNC) ? func_hold : hold_load(octrl00_reset_duration);
    escalate  = func_reset_req && (kind == KIND_AFU);
  end

  // Sequencer: state, kind, counters and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_POR;
      kind              <= KIND_FUNC;
      hold_cnt          <= '0;
      quiesce_cnt       <= '0;
      afu_reset         <= 1'b1;
      func_reset_active <= 1'b1;
      afu_reset_active  <= 1'b0;
      reset_done        <= 1'b0;
      quiesce_timeout   <= 1'b0;
    end else begin
      reset_done      <= 1'b0;
      quiesce_timeout <= 1'b0;
      case (state)
        S_POR: begin
          // Power-on: AFU is already held in reset, so skip the quiesce wait.
          hold_cnt  <= func_hold;
          afu_reset <= 1'b1;
          state     <= S_ASSERT;
        end

        S_IDLE, S_RELEASE: begin
          afu_reset         <= 1'b0;
          func_reset_active <= 1'b0;
          afu_reset_active  <= 1'b0;
          if (func_reset_req) begin
            // Function reset wins; a simultaneous AFU request is absorbed.
            kind              <= KIND_FUNC;
            func_reset_active <= 1'b1;
            state             <= S_QUIESCE;
          end else if (afu_reset_req) begin
            kind             <= KIND_AFU;
            afu_reset_active <= 1'b1;
            state            <= S_QUIESCE;
          end else begin
            state <= S_IDLE;
          end
        end

        S_QUIESCE: begin
          if (escalate) begin
            // Upgrade to a function reset and restart the quiesce wait.
            kind              <= KIND_FUNC;
            func_reset_active <= 1'b1;
            afu_reset_active  <= 1'b0;
            quiesce_cnt       <= '0;
          end else if (afu_quiesced) begin
            hold_cnt    <= kind_hold;
            quiesce_cnt <= '0;
            afu_reset   <= 1'b1;
            state       <= S_ASSERT;
          end else if (quiesce_cnt == QCNT_LAST) begin
            // AFU never drained; reset it anyway and flag the timeout.
            hold_cnt        <= kind_hold;
            quiesce_cnt     <= '0;
            quiesce_timeout <= 1'b1;
            afu_reset       <= 1'b1;
            state           <= S_ASSERT;
          end else begin
            quiesce_cnt <= quiesce_cnt + QCNT_W'(1);
          end
        end

        S_ASSERT: begin
          if (escalate) begin
            // AFU is already in reset: just restart the hold with the function duration.
            kind              <= KIND_FUNC;
            func_reset_active <= 1'b1;
            afu_reset_active  <= 1'b0;
            hold_cnt          <= func_hold;
          end else if (hold_cnt == HOLD_ONE) begin
            hold_cnt          <= '0;
            afu_reset         <= 1'b0;
            reset_done        <= 1'b1;
            func_reset_active <= 1'b0;
            afu_reset_active  <= 1'b0;
            state             <= S_RELEASE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_ONE;
          end
        end

        default: begin
          afu_reset <= 1'b1;
          state     <= S_POR;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfg_afu_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfg_afu_reset_seq
//  Description : Scoreboard bench for cfg_afu_reset_seq. Each sequence is
//                turned into a timeline of expected output-vector changes
//                {afu_reset, func_active, afu_active, reset_done, timeout}
//                which a monitor compares against every observed change.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cfg_afu_reset_seq;

  localparam int ULOG = 4;
  localparam int QT   = 1024;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       func_reset_req = 1'b0;
  logic       afu_reset_req = 1'b0;
  logic [7:0] ofunc_reset_duration = 8'h10;
  logic [7:0] octrl00_reset_duration = 8'h10;
  logic       afu_quiesced = 1'b0;
  logic       afu_reset;
  logic       func_reset_active;
  logic       afu_reset_active;
  logic       reset_done;
  logic       quiesce_timeout;

  cfg_afu_reset_seq #(
    .UNIT_LOG2       (ULOG),
    .QUIESCE_TIMEOUT (QT)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .func_reset_req         (func_reset_req),
    .afu_reset_req          (afu_reset_req),
    .ofunc_reset_duration   (ofunc_reset_duration),
    .octrl00_reset_duration (octrl00_reset_duration),
    .afu_quiesced           (afu_quiesced),
    .afu_reset              (afu_reset),
    .func_reset_active      (func_reset_active),
    .afu_reset_active       (afu_reset_active),
    .reset_done             (reset_done),
    .quiesce_timeout        (quiesce_timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [4:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [4:0] mon_prev = 5'b11000;
  logic [4:0] mon_cur;
  exp_t mon_e;

  // Reset length in cycles for a duration register value.
  function automatic int scale(input logic [7:0] d);
    return ((d == 8'd0) ? 1 : int'(d)) << ULOG;
  endfunction

  task automatic push(input int c, input logic [4:0] v);
    exp_t x;
    x.cyc = c;
    x.vec = v;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at cyc %0d", name, got, want, cyc);
    end
  endtask

  // Monitor: every change of the output vector must match the next expected entry.
  always @(negedge clock) begin
    if (mon_en) begin
      mon_cur = {afu_reset, func_reset_active, afu_reset_active, reset_done, quiesce_timeout};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_change: outputs %b at cyc %0d, required %b from cyc %0d",
                 mon_cur, cyc, mon_e.vec, mon_e.cyc);
      end
      if (mon_cur !== mon_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: outputs %b at cyc %0d, required no change from %b",
                   mon_cur, cyc, mon_prev);
        end else if (exp_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL change_timing: outputs %b at cyc %0d, required %b at cyc %0d",
                   mon_cur, cyc, exp_q[0].vec, exp_q[0].cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.vec !== mon_cur) begin
            errors++;
            $display("FAIL change_value: outputs %b at cyc %0d, required %b",
                     mon_cur, cyc, mon_e.vec);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  // POR after reset release at cycle r: hold for the function duration, then done.
  task automatic por_expect(input int r);
    int rel;
    rel = r + 1 + scale(ofunc_reset_duration);
    push(rel, 5'b00010);
    push(rel + 1, 5'b00000);
    while (cyc < rel + 3) @(negedge clock);
  endtask

  // One reset sequence issued now. kind: 0 func, 1 afu, 2 both.
  // q: QUIESCE cycles before the AFU reports quiesced (>= QT means never).
  // esc: 0 none, 1 func request in QUIESCE, 2 func request in ASSERT.
  task automatic run_seq(input int kind, input int q, input int esc, input int esc_off,
                         input logic [7:0] new_of, input logic [7:0] new_oc,
                         input bit b2b, input int gap);
    int t, a, e, rel, n, end_cyc;
    bit kf, ka, tmo;
    t   = cyc;
    kf  = (kind != 1);
    ka  = (kind == 1);
    tmo = (q >= QT);
    a   = tmo ? t + 1 + QT : t + 2 + q;
    e   = 0;
    if (esc == 1) begin
      e = t + 1 + esc_off;
      n = scale(ofunc_reset_duration);
    end else begin
      n = scale(kf ? ofunc_reset_duration : octrl00_reset_duration);
    end
    rel = a + n;
    if (esc == 2) begin
      e   = a + esc_off;
      rel = e + 1 + scale(new_of);
    end
    func_reset_req = kf;
    afu_reset_req  = (kind != 0);
    afu_quiesced   = (q == 0);
    push(t + 1, {1'b0, kf, ka, 2'b00});
    if (esc == 1) push(e + 1, 5'b01000);
    push(a, {1'b1, kf || (esc == 1), ka && (esc != 1), 1'b0, tmo});
    if (tmo) push(a + 1, {1'b1, kf, ka, 2'b00});
    if (esc == 2) push(e + 1, 5'b11000);
    push(rel, 5'b00010);
    if (!b2b) push(rel + 1, 5'b00000);
    end_cyc = b2b ? rel : rel + 1 + gap;
    while (cyc < end_cyc) begin
      @(negedge clock);
      func_reset_req = 1'b0;
      afu_reset_req  = 1'b0;
      if (!tmo && q > 0 && cyc == t + 1 + q) afu_quiesced = 1'b1;
      if (esc == 1 && cyc == e) func_reset_req = 1'b1;
      if (cyc == a) begin
        ofunc_reset_duration   = new_of;
        octrl00_reset_duration = new_oc;
      end
      if (cyc == a + 1) begin
        afu_reset_req  = 1'b1;
        func_reset_req = kf || (esc == 1);
      end
      if (esc == 2 && cyc == e) func_reset_req = 1'b1;
    end
  endtask

  // Async reset 50 cycles into an AFU reset, then the POR sequence again.
  task automatic reset_mid();
    int t, a;
    ofunc_reset_duration   = 8'h10;
    octrl00_reset_duration = 8'h10;
    t = cyc;
    a = t + 2;
    afu_reset_req = 1'b1;
    afu_quiesced  = 1'b1;
    push(t + 1, 5'b00100);
    push(a, 5'b10100);
    push(a + 51, 5'b11000);
    while (cyc < a + 50) begin
      @(negedge clock);
      afu_reset_req = 1'b0;
    end
    #1 reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      afu_reset_req = 1'b1;
      chk("mid_rst_afu_reset", int'(afu_reset), 1);
      chk("mid_rst_reset_done", int'(reset_done), 0);
      chk("mid_rst_qtimeout", int'(quiesce_timeout), 0);
      chk("mid_rst_func_active", int'(func_reset_active), 1);
      chk("mid_rst_afu_active", int'(afu_reset_active), 0);
    end
    afu_reset_req = 1'b0;
    #1 reset = 1'b0;
    por_expect(cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_afu_reset", int'(afu_reset), 1);
    chk("rst_func_active", int'(func_reset_active), 1);
    chk("rst_afu_active", int'(afu_reset_active), 0);
    chk("rst_reset_done", int'(reset_done), 0);
    chk("rst_qtimeout", int'(quiesce_timeout), 0);
    mon_en = 1'b1;
    #1 reset = 1'b0;
    por_expect(cyc);

    // AFU reset, already quiesced, 16 units.
    run_seq(1, 0, 0, 0, 8'h10, 8'h10, 1'b0, 2);
    // AFU never quiesces: timeout path.
    octrl00_reset_duration = 8'h02;
    run_seq(1, QT, 0, 0, 8'h10, 8'h02, 1'b0, 1);
    // Both requests together: function reset only.
    octrl00_reset_duration = 8'h10;
    run_seq(2, 0, 0, 0, 8'h10, 8'h10, 1'b0, 1);
    // Function request 100 cycles into an AFU ASSERT.
    run_seq(1, 0, 2, 100, 8'h10, 8'h10, 1'b0, 1);
    // Zero duration, and a new request in the RELEASE cycle.
    octrl00_reset_duration = 8'h00;
    run_seq(1, 0, 0, 0, 8'h10, 8'h00, 1'b1, 0);
    run_seq(1, 0, 0, 0, 8'h10, 8'h00, 1'b0, 1);
    // Escalation while still quiescing.
    ofunc_reset_duration   = 8'h02;
    octrl00_reset_duration = 8'h03;
    run_seq(1, 6, 1, 2, 8'h05, 8'h07, 1'b0, 1);

    for (int i = 0; i < 12; i++) begin
      int k, q, esc, off, g;
      logic [7:0] nof, noc;
      bit b2b;
      k = int'($urandom_range(0, 2));
      ofunc_reset_duration   = 8'($urandom_range(0, 31));
      octrl00_reset_duration = 8'($urandom_range(0, 31));
      q   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
      esc = 0;
      off = 0;
      if (k == 1) begin
        case ($urandom_range(0, 2))
          1: if (q > 0) begin
               esc = 1;
               off = int'($urandom_range(0, q - 1));
             end
          2: begin
               esc = 2;
               off = int'($urandom_range(2, scale(octrl00_reset_duration) - 1));
             end
          default: esc = 0;
        endcase
      end
      nof = 8'($urandom_range(0, 31));
      noc = 8'($urandom_range(0, 31));
      b2b = (i < 11) && ($urandom_range(0, 1) == 1);
      g   = int'($urandom_range(0, 3));
      run_seq(k, q, esc, off, nof, noc, b2b, g);
    end

    reset_mid();

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_afu_reset", int'(afu_reset), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
